// File: rtl/alu_issue_pkg.sv
// Shared instruction definitions for the ALU issue block.
// Holds the MIPS opcode/funct codes, the ALU result latency and the
// instruction class encoding used by the decoder and the issue logic.
package alu_issue_pkg;

  // Cycles from operands driven to alu_rslt valid.
  localparam int ALU_LATENCY = 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_MEM   = 2'd1,
    CLS_SHIFT = 2'd2,
    CLS_BAD   = 2'd3
  } iclass_e;

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational decode of a MIPS instruction word for the ALU issue block.
// Ports:
//   inst_i   : instruction word
//   cls_o    : instruction class (ALU, MEM, SHIFT, BAD)
//   dst_o    : destination register (0 for SW and unsupported)
//   wb_mem_o : result is a memory address (LW/SW)
//   rs_o/rt_o: source register fields
//   use_rs_o : rs feeds the ALU
//   use_rt_o : rt feeds the ALU (R-type only)
//   shamt_o  : shift amount field
module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [31:0] inst_i,
  output iclass_e     cls_o,
  output logic [4:0]  dst_o,
  output logic        wb_mem_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic        use_rs_o,
  output logic        use_rt_o,
  output logic [4:0]  shamt_o
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode  = inst_i[31:26];
  assign funct   = inst_i[5:0];
  assign rs_o    = inst_i[25:21];
  assign rt_o    = inst_i[20:16];
  assign shamt_o = inst_i[10:6];

  always_comb begin
    cls_o    = CLS_BAD;
    dst_o    = 5'd0;
    wb_mem_o = 1'b0;
    use_rs_o = 1'b0;
    use_rt_o = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_SRL: begin
            cls_o    = CLS_SHIFT;
            dst_o    = inst_i[15:11];
            use_rt_o = 1'b1;
          end
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            cls_o    = CLS_ALU;
            dst_o    = inst_i[15:11];
            use_rs_o = 1'b1;
            use_rt_o = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        cls_o    = CLS_ALU;
        dst_o    = inst_i[20:16];
        use_rs_o = 1'b1;
      end
      OP_LW: begin
        cls_o    = CLS_MEM;
        dst_o    = inst_i[20:16];
        wb_mem_o = 1'b1;
        use_rs_o = 1'b1;
      end
      OP_SW: begin
        cls_o    = CLS_MEM;
        wb_mem_o = 1'b1;
        use_rs_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accepts MIPS instructions, drives fields and operands to
// an external single-cycle ALU, forwards the previous result over stale
// register reads, and delivers the result one cycle after the final pass.
// Long SLL/SRL are split into passes of at most SHAMT_STEP when the macro
// ALU_ISSUE_SHIFT_SPLIT_EN is defined; otherwise they are dropped with err.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : instruction handshake; in_inst, in_rrs, in_rrt
//   alu_opcode/funct/imm/shamt, alu_rrs/alu_rrt : ALU request
//   alu_rslt             : ALU result, one cycle after request
//   wb_valid/wb_reg/wb_mem/wb_data : result delivery
//   err                  : pulse for a dropped instruction
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned SHAMT_STEP = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_rrs,
  input  logic [31:0] in_rrt,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_funct,
  output logic [15:0] alu_imm,
  output logic [4:0]  alu_shamt,
  output logic [31:0] alu_rrs,
  output logic [31:0] alu_rrt,
  input  logic [31:0] alu_rslt,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic        wb_mem,
  output logic [31:0] wb_data,
  output logic        err
);

  localparam logic [4:0] STEP = 5'(SHAMT_STEP);

  iclass_e    dec_cls;
  logic [4:0] dec_dst;
  logic       dec_mem;
  logic [4:0] dec_rs;
  logic [4:0] dec_rt;
  logic       dec_use_rs;
  logic       dec_use_rt;
  logic [4:0] dec_shamt;

  alu_issue_dec u_dec (
    .inst_i   (in_inst),
    .cls_o    (dec_cls),
    .dst_o    (dec_dst),
    .wb_mem_o (dec_mem),
    .rs_o     (dec_rs),
    .rt_o     (dec_rt),
    .use_rs_o (dec_use_rs),
    .use_rt_o (dec_use_rt),
    .shamt_o  (dec_shamt)
  );

  logic       wb_valid_q, wb_valid_d;
  logic [4:0] wb_reg_q,   wb_reg_d;
  logic       wb_mem_q,   wb_mem_d;
  logic       err_q,      err_d;
  logic       running;
  logic       accept;
  logic       long_shift;
  logic       fwd_rs;
  logic       fwd_rt;

`ifdef ALU_ISSUE_SHIFT_SPLIT_EN
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [4:0] rem_q,   rem_d;
  logic [5:0] funct_q, funct_d;
  logic [4:0] dst_q,   dst_d;

  assign running = (state_q == ST_RUN);
`else
  assign running = 1'b1;
`endif

  assign in_ready   = running & ~rst;
  assign accept     = in_valid & in_ready;
  assign long_shift = (dec_cls == CLS_SHIFT) && (dec_shamt > STEP);

  // The result arriving this cycle belongs to the instruction being written
  // back; the register file has not seen it yet. r0 and addresses never bypass.
  assign fwd_rs = wb_valid_q & ~wb_mem_q & (wb_reg_q != 5'd0) &
                  (wb_reg_q == dec_rs) & dec_use_rs;
  assign fwd_rt = wb_valid_q & ~wb_mem_q & (wb_reg_q != 5'd0) &
                  (wb_reg_q == dec_rt) & dec_use_rt;

  always_comb begin
    alu_opcode = in_inst[31:26];
    alu_funct  = in_inst[5:0];
    alu_imm    = in_inst[15:0];
    alu_shamt  = long_shift ? STEP : dec_shamt;
    alu_rrs    = fwd_rs ? alu_rslt : in_rrs;
    alu_rrt    = fwd_rt ? alu_rslt : in_rrt;
`ifdef ALU_ISSUE_SHIFT_SPLIT_EN
    // Continuation pass: the partial shift result feeds back as rt.
    if (state_q == ST_SHIFT) begin
      alu_opcode = OP_RTYPE;
      alu_funct  = funct_q;
      alu_imm    = 16'h0000;
      alu_shamt  = (rem_q > STEP) ? STEP : rem_q;
      alu_rrs    = 32'h0000_0000;
      alu_rrt    = alu_rslt;
    end
`endif
  end

  always_comb begin
    wb_valid_d = 1'b0;
    wb_reg_d   = 5'd0;
    wb_mem_d   = 1'b0;
    err_d      = 1'b0;
`ifdef ALU_ISSUE_SHIFT_SPLIT_EN
    state_d    = state_q;
    rem_d      = rem_q;
    funct_d    = funct_q;
    dst_d      = dst_q;
    if (state_q == ST_SHIFT) begin
      if (rem_q <= STEP) begin
        state_d    = ST_RUN;
        rem_d      = 5'd0;
        wb_valid_d = 1'b1;
        wb_reg_d   = dst_q;
      end else begin
        rem_d = rem_q - STEP;
      end
    end else
`endif
    if (accept) begin
      if (dec_cls == CLS_BAD) begin
        err_d = 1'b1;
      end else if (long_shift) begin
`ifdef ALU_ISSUE_SHIFT_SPLIT_EN
        state_d = ST_SHIFT;
        rem_d   = dec_shamt - STEP;
        funct_d = in_inst[5:0];
        dst_d   = dec_dst;
`else
        err_d   = 1'b1;
`endif
      end else begin
        wb_valid_d = 1'b1;
        wb_reg_d   = dec_dst;
        wb_mem_d   = dec_mem;
      end
    end
  end

  // Result stage boundary: tags line up with alu_rslt one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_reg_q   <= 5'd0;
      wb_mem_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef ALU_ISSUE_SHIFT_SPLIT_EN
      state_q    <= ST_RUN;
      rem_q      <= 5'd0;
`endif
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_mem_q   <= wb_mem_d;
      err_q      <= err_d;
`ifdef ALU_ISSUE_SHIFT_SPLIT_EN
      state_q    <= state_d;
      rem_q      <= rem_d;
`endif
    end
  end

`ifdef ALU_ISSUE_SHIFT_SPLIT_EN
  always_ff @(posedge clk) begin
    funct_q <= funct_d;
    dst_q   <= dst_d;
  end
`endif

  assign wb_valid = wb_valid_q;
  assign wb_reg   = wb_reg_q;
  assign wb_mem   = wb_mem_q;
  assign wb_data  = alu_rslt;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  localparam int STEP = 7;
`ifdef ALU_ISSUE_SHIFT_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_ADDIU = 6'h09,
    OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
    OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20,
    F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
    F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [5:0] RFN [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                      6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  localparam logic [5:0] IOP [7] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                                     6'h0D, 6'h0E};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_inst, in_rrs, in_rrt;
  logic [5:0]  alu_opcode, alu_funct;
  logic [15:0] alu_imm;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_rrs, alu_rrt, alu_rslt;
  logic        wb_valid, wb_mem, err;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  alu_issue #(.SHAMT_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_rrs(in_rrs), .in_rrt(in_rrt),
    .alu_opcode(alu_opcode), .alu_funct(alu_funct), .alu_imm(alu_imm),
    .alu_shamt(alu_shamt), .alu_rrs(alu_rrs), .alu_rrt(alu_rrt),
    .alu_rslt(alu_rslt), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .wb_mem(wb_mem), .wb_data(wb_data), .err(err)
  );

  // MIPS instruction semantics (wrapping arithmetic, no overflow trap).
  function automatic logic [31:0] isa_exec(input logic [5:0] op, input logic [5:0] fn,
      input logic [15:0] imm, input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] se, ze;
    se = {{16{imm[15]}}, imm};
    ze = {16'h0000, imm};
    case (op)
      OP_R: case (fn)
        F_SLL: return b << sh;
        F_SRL: return b >> sh;
        F_ADD, F_ADDU: return a + b;
        F_SUB, F_SUBU: return a - b;
        F_AND: return a & b;
        F_OR:  return a | b;
        F_XOR: return a ^ b;
        F_NOR: return ~(a | b);
        F_SLT: return {31'd0, $signed(a) < $signed(b)};
        F_SLTU: return {31'd0, a < b};
        default: return 32'h0;
      endcase
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: return a + se;
      OP_SLTI:  return {31'd0, $signed(a) < $signed(se)};
      OP_SLTIU: return {31'd0, a < se};
      OP_ANDI:  return a & ze;
      OP_ORI:   return a | ze;
      OP_XORI:  return a ^ ze;
      default:  return 32'h0;
    endcase
  endfunction

  // External single-cycle ALU.
  always @(posedge clk)
    alu_rslt <= isa_exec(alu_opcode, alu_funct, alu_imm, alu_shamt, alu_rrs, alu_rrt);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [4:0]  rg;
    bit          mem;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] arch [32];
  int          prev_wb_cyc = -1;
  logic [4:0]  prev_dst = 5'd0;
  logic [31:0] prev_old = 32'h0;

  // Number of ALU cycles an instruction occupies; -1 when it is dropped.
  function automatic int passes_of(input logic [31:0] inst);
    logic [5:0] op, fn;
    int s;
    op = inst[31:26];
    fn = inst[5:0];
    s  = int'(inst[10:6]);
    if (op == OP_R) begin
      if (fn == F_SLL || fn == F_SRL) begin
        if (s <= STEP) return 1;
        return SPLIT ? (s + STEP - 1) / STEP : -1;
      end
      foreach (RFN[i]) if (RFN[i] == fn) return 1;
      return -1;
    end
    foreach (IOP[i]) if (IOP[i] == op) return 1;
    if (op == OP_LW || op == OP_SW) return 1;
    return -1;
  endfunction

  // Register file as seen by the issue stage: the value written back this
  // very cycle is not yet visible.
  function automatic logic [31:0] opval(input logic [4:0] r);
    if (prev_wb_cyc == cyc && prev_dst == r) return prev_old;
    return arch[r];
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh);
    return {OP_R, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] inst);
    int w, p, c;
    logic [4:0] rs, rt, d;
    logic [5:0] op;
    bit mem;
    logic [31:0] r;
    exp_t e;
    rs = inst[25:21];
    rt = inst[20:16];
    op = inst[31:26];
    in_valid = 1'b1;
    in_inst  = inst;
    w = 0;
    forever begin
      in_rrs = opval(rs);
      in_rrt = opval(rt);
      #1;
      if (in_ready === 1'b1) break;
      @(negedge clk);
      w++;
      if (w > 40) begin
        $display("FAIL accept_timeout: in_ready low %0d cycles, want high", w);
        $fatal(1, "accept timeout");
      end
    end
    c = cyc;
    p = passes_of(inst);
    if (p < 0) begin
      e = '{1'b1, 5'd0, 1'b0, 32'h0, c + 1};
      prev_wb_cyc = -1;
    end else begin
      mem = (op == OP_LW || op == OP_SW);
      d   = (op == OP_R) ? inst[15:11] : (op == OP_SW) ? 5'd0 : rt;
      r   = isa_exec(op, inst[5:0], inst[15:0], inst[10:6], arch[rs], arch[rt]);
      e   = '{1'b0, d, mem, r, c + p};
      if (!mem && d != 5'd0) begin
        prev_old    = arch[d];
        arch[d]     = r;
        prev_dst    = d;
        prev_wb_cyc = c + p;
      end else begin
        prev_wb_cyc = -1;
      end
    end
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] imm;
    int k;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    sh  = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    k   = $urandom_range(0, 9);
    if (k <= 3) return rtype(RFN[$urandom_range(0, 9)], rs, rt, rd, 5'd0);
    if (k == 4) return rtype(($urandom_range(0, 1) != 0) ? F_SLL : F_SRL, 5'd0, rt, rd, sh);
    if (k <= 7) return itype(IOP[$urandom_range(0, 6)], rs, rt, imm);
    if (k == 8) return itype(($urandom_range(0, 1) != 0) ? OP_LW : OP_SW, rs, rt, imm);
    case ($urandom_range(0, 2))
      0:       return {6'h3F, 26'($urandom)};
      1:       return rtype(6'h08, rs, rt, rd, 5'd0);
      default: return {6'h02, 26'($urandom)};
    endcase
  endfunction

  // Output monitor: every delivery or error pulse must match the head of
  // the scoreboard in content and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_out: nothing by cycle %0d, want err=%0b reg=%0d data=%h at cycle %0d",
               cyc, sbq[0].is_err, sbq[0].rg, sbq[0].data, sbq[0].cyc);
      void'(sbq.pop_front());
    end
    if (wb_valid || err) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: cycle %0d wb_valid=%0b err=%0b reg=%0d data=%h, want none",
                 cyc, wb_valid, err, wb_reg, wb_data);
      end else begin
        e = sbq.pop_front();
        if (e.cyc != cyc || err != e.is_err || wb_valid != !e.is_err ||
            (!e.is_err && (wb_reg != e.rg || wb_mem != e.mem || wb_data != e.data))) begin
          errors++;
          $display("FAIL out_cmp: got cyc=%0d err=%0b wb=%0b reg=%0d mem=%0b data=%h, want cyc=%0d err=%0b reg=%0d mem=%0b data=%h",
                   cyc, err, wb_valid, wb_reg, wb_mem, wb_data,
                   e.cyc, e.is_err, e.rg, e.mem, e.data);
        end
      end
    end
  end

  initial begin
    int lowc, w;
    foreach (arch[i]) arch[i] = 32'h0;
    rst = 1'b1; in_valid = 1'b0; in_inst = 32'h0; in_rrs = 32'h0; in_rrt = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_err",      {31'd0, err},      32'd0);
    chk("rst_wb_reg",   {27'd0, wb_reg},   32'd0);
    chk("rst_wb_mem",   {31'd0, wb_mem},   32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wb_data",  wb_data,           alu_rslt);
    rst = 1'b0;
    @(negedge clk);

    // Dependent pair with a stale rs read.
    issue(itype(OP_ADDI, 5'd0, 5'd1, 16'd5));
    issue(rtype(F_ADD, 5'd1, 5'd1, 5'd2, 5'd0));
    idle(2);

    // Full-width shift: in_ready drop while passes run.
    issue(itype(OP_ADDI, 5'd0, 5'd4, 16'd1));
    issue(rtype(F_SLL, 5'd0, 5'd4, 5'd3, 5'd31));
    lowc = 0;
    while (in_ready == 1'b0 && lowc < 20) begin
      @(negedge clk);
      lowc++;
    end
    chk("shift31_ready_low", lowc, SPLIT ? 32'd4 : 32'd0);
    idle(3);

    issue(itype(OP_ORI, 5'd0, 5'd6, 16'hFF00));
    issue(rtype(F_SRL, 5'd0, 5'd6, 5'd5, 5'd8));
    issue(rtype(F_SRL, 5'd0, 5'd6, 5'd7, 5'd0));
    idle(2);

    issue(itype(OP_ORI, 5'd0, 5'd9, 16'h0100));
    issue(itype(OP_SW, 5'd9, 5'd10, 16'hFFFC));
    issue(rtype(F_ADDU, 5'd0, 5'd0, 5'd11, 5'd0));
    issue(32'hFC00_0000);
    idle(2);

    issue(rtype(F_SLL, 5'd0, 5'd4, 5'd3, 5'd9));
    issue(rtype(F_SLL, 5'd0, 5'd4, 5'd3, 5'd7));
    idle(2);

`ifdef ALU_ISSUE_SHIFT_SPLIT_EN
    // Reset while the third pass is on the ALU: the shift is abandoned.
    issue(rtype(F_SLL, 5'd0, 5'd4, 5'd13, 5'd31));
    @(negedge clk);
    rst = 1'b1;
    void'(sbq.pop_back());
    arch[13] = prev_old;
    prev_wb_cyc = -1;
    @(negedge clk);
`else
    rst = 1'b1;
    @(negedge clk);
`endif
    chk("in_ready_during_rst", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    idle(6);

    repeat (400) begin
      issue(rand_inst());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    w = 0;
    while (sbq.size() > 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, want 0", sbq.size());
    end
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
